// File: rtl/pwm_multicanal_if.sv
// Control/status bundle for pwm_multicanal. The master side drives the controls and duty writes.
// The slave side is the PWM block and returns the outputs.
interface pwm_multicanal_if #(
    parameter int unsigned CHANNELS    = 4,
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned PRESC_WIDTH = 3
);
    localparam int unsigned LCH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    logic                   enable;
    logic [PRESC_WIDTH-1:0] speed;
    logic                   mode;
    logic                   load;
    logic [LCH_W-1:0]       load_ch;
    logic [WIDTH-1:0]       load_duty;
    logic [CHANNELS-1:0]    pwm;
    logic                   period_start;

    modport master (
        output enable, speed, mode, load, load_ch, load_duty,
        input  pwm, period_start
    );

    modport slave (
        input  enable, speed, mode, load, load_ch, load_duty,
        output pwm, period_start
    );
endinterface

// File: rtl/pwm_multicanal.sv
// Multi-channel PWM built on one shared prescaler and one period counter (edge- or center-aligned).
// Each channel has a double-buffered duty: a shadow register is promoted to the active register at each period boundary.
module pwm_multicanal #(
    parameter int unsigned CHANNELS    = 4,
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned PRESC_WIDTH = 3
) (
    input  logic            clock,
    input  logic            reset,
    pwm_multicanal_if.slave bus
);
    localparam int unsigned PC_W  = (1 << PRESC_WIDTH) - 1;
    localparam int unsigned LCH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    localparam logic [WIDTH-1:0] CNT_MAX  = '1;
    localparam logic [WIDTH-1:0] CNT_ONE  = WIDTH'(1);
    localparam logic [PC_W-1:0]  PC_ONES  = '1;
    localparam logic [0:0]       DIR_UP   = 1'b0;
    localparam logic [0:0]       DIR_DOWN = 1'b1;

    logic [PC_W-1:0]     pc_q, pc_d;
    logic [WIDTH-1:0]    cnt_q, cnt_d;
    logic [0:0]          dir_q, dir_d;
    logic                mode_q, mode_d;
    logic [WIDTH-1:0]    shadow_q [CHANNELS];
    logic [WIDTH-1:0]    shadow_d [CHANNELS];
    logic [WIDTH-1:0]    active_q [CHANNELS];
    logic [WIDTH-1:0]    active_d [CHANNELS];
    logic [CHANNELS-1:0] pwm_q, pwm_d;
    logic                ps_q, ps_d;

    logic [PC_W-1:0]     pc_thr;
    logic                tick;
    logic                boundary;

    // Next-state logic: duty writes, prescaler, counter, boundary promotion and outputs.
    always_comb begin
        pc_d     = pc_q;
        cnt_d    = cnt_q;
        dir_d    = dir_q;
        mode_d   = mode_q;
        shadow_d = shadow_q;
        active_d = active_q;
        pwm_d    = '0;
        ps_d     = 1'b0;
        tick     = 1'b0;
        boundary = 1'b0;
        pc_thr   = ~(PC_ONES << bus.speed);

        // Indices at or above CHANNELS match no channel, so those writes are dropped.
        for (int i = 0; i < int'(CHANNELS); i++) begin
            if (bus.load && (bus.load_ch == LCH_W'(i))) begin
                shadow_d[i] = bus.load_duty;
            end
        end

        if (!bus.enable) begin
            pc_d     = '0;
            cnt_d    = '0;
            dir_d    = DIR_UP;
            mode_d   = bus.mode;
            active_d = shadow_q;
        end else begin
            // Threshold comparison with >= keeps a live speed decrease from waiting for a full wrap.
            tick = (pc_q >= pc_thr);
            pc_d = tick ? '0 : pc_q + PC_W'(1);

            if (tick) begin
                if (!mode_q) begin
                    cnt_d    = cnt_q + CNT_ONE;
                    boundary = (cnt_q == CNT_MAX);
                end else if (dir_q == DIR_UP) begin
                    cnt_d = cnt_q + CNT_ONE;
                    if (cnt_q == (CNT_MAX - CNT_ONE)) begin
                        dir_d = DIR_DOWN;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                    if (cnt_q == CNT_ONE) begin
                        dir_d    = DIR_UP;
                        boundary = 1'b1;
                    end
                end
            end

            // Active duties take the pre-write shadow, so a write on this cycle waits one period.
            if (boundary) begin
                active_d = shadow_q;
                mode_d   = bus.mode;
                dir_d    = DIR_UP;
                ps_d     = 1'b1;
            end
        end

        for (int i = 0; i < int'(CHANNELS); i++) begin
            pwm_d[i] = bus.enable & (cnt_q < active_q[i]);
        end
    end

    // State register; reset overrides enable and load.
    always_ff @(posedge clock) begin
        if (reset) begin
            pc_q     <= '0;
            cnt_q    <= '0;
            dir_q    <= DIR_UP;
            mode_q   <= 1'b0;
            shadow_q <= '{default: '0};
            active_q <= '{default: '0};
            pwm_q    <= '0;
            ps_q     <= 1'b0;
        end else begin
            pc_q     <= pc_d;
            cnt_q    <= cnt_d;
            dir_q    <= dir_d;
            mode_q   <= mode_d;
            shadow_q <= shadow_d;
            active_q <= active_d;
            pwm_q    <= pwm_d;
            ps_q     <= ps_d;
        end
    end

    assign bus.pwm          = pwm_q;
    assign bus.period_start = ps_q;

endmodule

// File: tb/tb_pwm_multicanal.sv
// Directed bench for pwm_multicanal with WIDTH=4 and five channels.
// Outputs are sampled on the falling edge and high-time is counted over windows aligned to period_start.
module tb_pwm_multicanal;
    localparam int unsigned CH = 5;
    localparam int unsigned W  = 4;
    localparam int unsigned PW = 3;

    logic clock;
    logic reset;

    pwm_multicanal_if #(.CHANNELS(CH), .WIDTH(W), .PRESC_WIDTH(PW)) bus ();

    pwm_multicanal #(.CHANNELS(CH), .WIDTH(W), .PRESC_WIDTH(PW)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;
    int hi [CH];
    int ps_cnt;
    int first0;
    int last0;
    int waited;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Count high samples per channel and period_start pulses over n falling edges.
    task automatic measure(input int n);
        for (int c = 0; c < int'(CH); c++) hi[c] = 0;
        ps_cnt = 0;
        first0 = 0;
        last0  = 0;
        for (int j = 1; j <= n; j++) begin
            @(negedge clock);
            for (int c = 0; c < int'(CH); c++) begin
                if (bus.pwm[c]) hi[c]++;
            end
            if (bus.period_start) ps_cnt++;
            if (bus.pwm[0]) begin
                if (first0 == 0) first0 = j;
                last0 = j;
            end
        end
    endtask

    // Falling edges until period_start is seen; bounded so a dead counter cannot hang the run.
    task automatic wait_ps();
        waited = 0;
        for (int j = 0; j < 300; j++) begin
            @(negedge clock);
            waited++;
            if (bus.period_start) break;
        end
    endtask

    task automatic write_duty(input int ch, input int d);
        bus.load      = 1'b1;
        bus.load_ch   = 3'(ch);
        bus.load_duty = 4'(d);
        @(negedge clock);
        bus.load      = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        reset         = 1'b1;
        bus.enable    = 1'b0;
        bus.speed     = '0;
        bus.mode      = 1'b0;
        bus.load      = 1'b0;
        bus.load_ch   = '0;
        bus.load_duty = '0;
        repeat (2) @(negedge clock);
        chk("reset_pwm", int'(bus.pwm), 0);
        chk("reset_ps", int'(bus.period_start), 0);
        reset = 1'b0;

        // Duties written while disabled take effect immediately.
        write_duty(0, 5);
        write_duty(2, 15);
        write_duty(3, 0);
        repeat (2) @(negedge clock);
        chk("disabled_pwm", int'(bus.pwm), 0);

        bus.enable = 1'b1;
        wait_ps();
        chk("first_ps_delay", waited, 16);

        measure(16);
        chk("edge_hi0", hi[0], 5);
        chk("edge_first0", first0, 1);
        chk("edge_ps", ps_cnt, 1);
        chk("edge_max_hi2", hi[2], 15);
        chk("edge_zero_hi1", hi[1], 0);
        chk("edge_zero_hi3", hi[3], 0);
        measure(16);
        chk("edge2_hi0", hi[0], 5);
        chk("edge2_ps", ps_cnt, 1);

        // Prescaler /4.
        bus.speed = 3'd2;
        measure(64);
        chk("presc_hi0", hi[0], 20);
        chk("presc_hi2", hi[2], 60);
        chk("presc_ps", ps_cnt, 1);
        chk("presc_last_ps", int'(bus.period_start), 1);
        bus.speed = 3'd0;

        // Mid-period write is deferred to the next period.
        measure(6);
        chk("mid_hi0_a", hi[0], 5);
        write_duty(0, 12);
        measure(9);
        chk("mid_hi0_b", hi[0], 0);
        chk("mid_ps", ps_cnt, 1);
        measure(16);
        chk("mid_new_hi0", hi[0], 12);
        chk("mid_new_ps", ps_cnt, 1);

        // Write landing on the boundary cycle waits one full extra period.
        measure(15);
        chk("bnd_pre_hi0", hi[0], 12);
        chk("bnd_pre_ps", ps_cnt, 0);
        write_duty(0, 3);
        chk("bnd_ps", int'(bus.period_start), 1);
        measure(16);
        chk("bnd_old_hi0", hi[0], 12);
        measure(16);
        chk("bnd_new_hi0", hi[0], 3);
        chk("bnd_new_ps", ps_cnt, 1);

        // Out-of-range channel indices are ignored.
        measure(4);
        write_duty(5, 9);
        write_duty(7, 1);
        measure(10);
        chk("oor_ps", ps_cnt, 1);
        measure(16);
        chk("oor_hi0", hi[0], 3);
        chk("oor_hi1", hi[1], 0);
        chk("oor_hi2", hi[2], 15);
        chk("oor_hi4", hi[4], 0);

        // Center mode with duty 4; mode change mid-period waits for the boundary.
        measure(5);
        write_duty(0, 4);
        measure(10);
        chk("c_prep_ps", ps_cnt, 1);
        measure(8);
        chk("c_edge_hi0", hi[0], 4);
        bus.mode = 1'b1;
        measure(8);
        chk("c_edge_tail_hi0", hi[0], 0);
        chk("c_edge_tail_ps", ps_cnt, 1);
        measure(30);
        chk("center_hi0", hi[0], 7);
        chk("center_first0", first0, 1);
        chk("center_last0", last0, 30);
        chk("center_hi2", hi[2], 29);
        chk("center_ps", ps_cnt, 1);
        measure(30);
        chk("center2_hi0", hi[0], 7);
        chk("center2_ps", ps_cnt, 1);

        // Disable mid-period, then re-enable in edge mode.
        measure(3);
        chk("pre_dis_hi0", hi[0], 3);
        bus.enable = 1'b0;
        bus.mode   = 1'b0;
        @(negedge clock);
        chk("dis_pwm", int'(bus.pwm), 0);
        chk("dis_ps", int'(bus.period_start), 0);
        repeat (3) @(negedge clock);
        chk("dis_hold_pwm", int'(bus.pwm), 0);
        bus.enable = 1'b1;
        wait_ps();
        chk("reen_ps_delay", waited, 16);
        measure(16);
        chk("reen_hi0", hi[0], 4);
        chk("reen_hi2", hi[2], 15);
        chk("reen_ps", ps_cnt, 1);

        // Reset wins over a simultaneous duty write.
        reset         = 1'b1;
        bus.load      = 1'b1;
        bus.load_ch   = 3'd1;
        bus.load_duty = 4'd9;
        @(negedge clock);
        chk("rst_pwm", int'(bus.pwm), 0);
        chk("rst_ps", int'(bus.period_start), 0);
        reset    = 1'b0;
        bus.load = 1'b0;
        wait_ps();
        chk("rst_ps_delay", waited, 16);
        measure(16);
        chk("rst_hi0", hi[0], 0);
        chk("rst_hi1", hi[1], 0);
        chk("rst_hi2", hi[2], 0);
        chk("rst_ps_cnt", ps_cnt, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
